aes_stream_ifc: RTL and testbench

Parametrised word-serial wrapper around the 128-bit AES cipher core, successor to the fixed 32-bit input/output buffer pair. It gathers BUS_W-bit key/text beats into 128-bit blocks under a valid/ready handshake and issues a one-cycle load to the core. It captures the core result on done and serialises it back out under a second valid/ready handshake. Key reuse is supported per block, and collection of the next block overlaps the core run and the output drain.

---
 rtl/aes_stream_ifc.sv | 132 +++++++++++++
 tb/tb_aes_stream_ifc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ifc.sv
// aes_stream_ifc: word-serial front end for a 128-bit AES cipher core.
// Collects BUS_W-bit key/text beats (MSW first) into 128-bit blocks and
// pulses core_ld for one cycle. It captures the core result on core_done and
// streams it back out MSW first, with out_last on the final beat.
// Collection of the next block overlaps the core run and the output drain.
// Ports:
//   clk, rst (async, active low)
//   in_vld/in_rdy/in_key/in_text/in_key_keep  input beat stream
//   core_ld/core_key/core_text                load to the cipher core
//   core_done/core_text_out                   result from the cipher core
//   out_vld/out_rdy/out_data/out_last         output beat stream
module aes_stream_ifc #(
  parameter int unsigned BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [BUS_W-1:0] in_key,
  input  logic [BUS_W-1:0] in_text,
  input  logic             in_key_keep,
  output logic             core_ld,
  output logic [127:0]     core_key,
  output logic [127:0]     core_text,
  input  logic             core_done,
  input  logic [127:0]     core_text_out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned WORDS = 128 / BUS_W;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  // Count value whose acceptance makes the next beat the last one.
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'((WORDS > 1) ? WORDS - 2 : 0);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             keep_blk;
  logic [127:0]     out_buf;
  logic             in_full;
  logic             key_wr;

  // in_rdy is stored directly; in_full is its complement.
  assign in_full = !in_rdy;

  // Output word is always the top of the draining shift register.
  assign out_data = out_buf[127 -: BUS_W];

  // Beat 0 decides key reuse from the live input, later beats from keep_blk.
  always_comb begin
    key_wr = 1'b0;
    if (in_cnt == '0) key_wr = !in_key_keep;
    else              key_wr = !keep_blk;
  end

  // Input gather, core load/capture FSM and output drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      keep_blk  <= 1'b0;
      in_rdy    <= 1'b1;
      core_ld   <= 1'b0;
      core_key  <= '0;
      core_text <= '0;
      out_buf   <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      core_ld <= 1'b0;

      // Input side: write word in_cnt, set in_full on the final beat.
      if (in_vld && in_rdy) begin
        for (int k = 0; k < int'(WORDS); k++) begin
          if (in_cnt == CNT_W'(k)) begin
            core_text[127 - k*BUS_W -: BUS_W] <= in_text;
            if (key_wr) core_key[127 - k*BUS_W -: BUS_W] <= in_key;
          end
        end
        if (in_cnt == '0) keep_blk <= in_key_keep;
        if (in_cnt == CNT_LAST) begin
          in_cnt <= '0;
          in_rdy <= 1'b0;
        end else begin
          in_cnt <= in_cnt + CNT_W'(1);
        end
      end

      // Core side: load only when the output buffer is empty (registered
      // out_vld, so a drain finishing this edge delays the load one cycle).
      case (state)
        ST_IDLE: begin
          if (in_full && !out_vld) begin
            state   <= ST_RUN;
            core_ld <= 1'b1;
            in_rdy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            state    <= ST_IDLE;
            out_buf  <= core_text_out;
            out_vld  <= 1'b1;
            out_cnt  <= '0;
            out_last <= (WORDS == 1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Output side: shift the next word up on each accepted beat.
      if (out_vld && out_rdy) begin
        out_cnt <= out_cnt + CNT_W'(1);
        if (out_last) begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
        end else begin
          out_buf  <= out_buf << BUS_W;
          out_last <= (out_cnt == CNT_PEN);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ifc.sv
// Directed bench for aes_stream_ifc at BUS_W=32 and BUS_W=8; the bench plays
// the cipher core, returning the FIPS-197 C.1 ciphertext on core_done.
module tb_aes_stream_ifc;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] GARB = 128'hdeadbeefcafef00d5a5a5a5aa5a5a5a5;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic drained;

  // BUS_W = 32 instance
  logic         a_in_vld, a_in_rdy, a_in_keep, a_core_ld, a_core_done;
  logic [31:0]  a_in_key, a_in_text, a_out_data;
  logic [127:0] a_core_key, a_core_text, a_core_out;
  logic         a_out_vld, a_out_rdy, a_out_last;

  // BUS_W = 8 instance
  logic         b_in_vld, b_in_rdy, b_in_keep, b_core_ld, b_core_done;
  logic [7:0]   b_in_key, b_in_text, b_out_data;
  logic [127:0] b_core_key, b_core_text, b_core_out;
  logic         b_out_vld, b_out_rdy, b_out_last;

  aes_stream_ifc #(.BUS_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_key(a_in_key), .in_text(a_in_text),
    .in_key_keep(a_in_keep),
    .core_ld(a_core_ld), .core_key(a_core_key), .core_text(a_core_text),
    .core_done(a_core_done), .core_text_out(a_core_out),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_data(a_out_data), .out_last(a_out_last)
  );

  aes_stream_ifc #(.BUS_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_key(b_in_key), .in_text(b_in_text),
    .in_key_keep(b_in_keep),
    .core_ld(b_core_ld), .core_key(b_core_key), .core_text(b_core_text),
    .core_done(b_core_done), .core_text_out(b_core_out),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_data(b_out_data), .out_last(b_out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Stream one block into dut_a; returns at the negedge after the last beat.
  task automatic send_a(input logic [127:0] key, input logic [127:0] text, input logic keep);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      a_in_vld  = 1'b1;
      a_in_key  = key[127 - 32*k -: 32];
      a_in_text = text[127 - 32*k -: 32];
      a_in_keep = keep;
      while (!a_in_rdy && n < TMO) begin @(negedge clk); n++; end
      chk("a_in_accept", a_in_rdy, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    a_in_vld  = 1'b0;
    a_in_key  = '0;
    a_in_text = '0;
    a_in_keep = 1'b0;
  endtask

  // Load expected one cycle after the last beat when the output is empty.
  task automatic expect_load_a(input logic [127:0] key, input logic [127:0] text);
    chk("a_rdy_low_after_last", a_in_rdy, 1'b0);
    chk("a_ld_not_yet", a_core_ld, 1'b0);
    @(negedge clk);
    chk("a_ld_high", a_core_ld, 1'b1);
    chk("a_rdy_back", a_in_rdy, 1'b1);
    chk("a_core_key", a_core_key, key);
    chk("a_core_text", a_core_text, text);
    @(negedge clk);
    chk("a_ld_one_cycle", a_core_ld, 1'b0);
  endtask

  task automatic core_a(input logic [127:0] ct, input int lat);
    repeat (lat) @(negedge clk);
    a_core_out  = ct;
    a_core_done = 1'b1;
    @(negedge clk);
    a_core_done = 1'b0;
  endtask

  task automatic recv_a(input logic [127:0] ct, input logic stall);
    for (int k = 0; k < 4; k++) begin
      int n;
      logic [31:0] w;
      n = 0;
      w = ct[127 - 32*k -: 32];
      while (!a_out_vld && n < TMO) begin @(negedge clk); n++; end
      chk("a_out_vld", a_out_vld, 1'b1);
      if (stall) begin
        a_out_rdy = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          chk("a_stall_data", a_out_data, w);
          chk("a_stall_vld", a_out_vld, 1'b1);
        end
      end
      a_out_rdy = 1'b1;
      chk("a_out_data", a_out_data, w);
      chk("a_out_last", a_out_last, k == 3);
      @(posedge clk);
      if (k == 3) drained = 1'b1;
      @(negedge clk);
      a_out_rdy = 1'b0;
      if (k == 3) begin
        chk("a_vld_after_drain", a_out_vld, 1'b0);
        chk("a_ld_low_after_last", a_core_ld, 1'b0);
      end
    end
  endtask

  task automatic send_b(input logic [127:0] key, input logic [127:0] text);
    for (int k = 0; k < 16; k++) begin
      int n;
      n = 0;
      b_in_vld  = 1'b1;
      b_in_key  = key[127 - 8*k -: 8];
      b_in_text = text[127 - 8*k -: 8];
      b_in_keep = 1'b0;
      while (!b_in_rdy && n < TMO) begin @(negedge clk); n++; end
      chk("b_in_accept", b_in_rdy, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    b_in_vld = 1'b0;
  endtask

  task automatic recv_b(input logic [127:0] ct);
    for (int k = 0; k < 16; k++) begin
      int n;
      logic [7:0] w;
      n = 0;
      w = ct[127 - 8*k -: 8];
      while (!b_out_vld && n < TMO) begin @(negedge clk); n++; end
      chk("b_out_vld", b_out_vld, 1'b1);
      b_out_rdy = 1'b1;
      chk("b_out_data", b_out_data, w);
      chk("b_out_last", b_out_last, k == 15);
      @(posedge clk);
      @(negedge clk);
      b_out_rdy = 1'b0;
    end
    chk("b_vld_after_drain", b_out_vld, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    drained = 1'b0;
    a_in_vld = 1'b0; a_in_key = '0; a_in_text = '0; a_in_keep = 1'b0;
    a_core_done = 1'b0; a_core_out = '0; a_out_rdy = 1'b0;
    b_in_vld = 1'b0; b_in_key = '0; b_in_text = '0; b_in_keep = 1'b0;
    b_core_done = 1'b0; b_core_out = '0; b_out_rdy = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_a_in_rdy", a_in_rdy, 1'b1);
    chk("rst_a_core_ld", a_core_ld, 1'b0);
    chk("rst_a_out_vld", a_out_vld, 1'b0);
    chk("rst_a_out_last", a_out_last, 1'b0);
    chk("rst_a_out_data", a_out_data, 32'h0);
    chk("rst_a_core_key", a_core_key, 128'h0);
    chk("rst_a_core_text", a_core_text, 128'h0);
    chk("rst_b_in_rdy", b_in_rdy, 1'b1);
    chk("rst_b_out_vld", b_out_vld, 1'b0);
    chk("rst_b_out_data", b_out_data, 8'h0);
    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 block, 32-bit beats
    send_a(KEY, PT, 1'b0);
    expect_load_a(KEY, PT);
    core_a(CT, 3);
    chk("a_vld_at_done", a_out_vld, 1'b1);
    chk("a_word0_at_done", a_out_data, 32'h69c4e0d8);
    recv_a(CT, 1'b0);

    // Key reuse: garbage key words must be ignored
    send_a(GARB, PT, 1'b1);
    expect_load_a(KEY, PT);
    core_a(CT, 5);
    recv_a(CT, 1'b0);

    // Backpressure with the next block collected during the drain
    send_a(KEY, PT, 1'b0);
    expect_load_a(KEY, PT);
    core_a(CT, 2);
    drained = 1'b0;
    fork
      begin
        send_a(KEY, PT2, 1'b0);
        chk("a_bp_rdy_low", a_in_rdy, 1'b0);
      end
      recv_a(CT, 1'b1);
      begin
        int n = 0;
        while (!a_core_ld && n < TMO) begin @(negedge clk); n++; end
        chk("a_bp_ld_seen", a_core_ld, 1'b1);
        chk("a_bp_ld_after_last", drained, 1'b1);
        chk("a_bp_core_text", a_core_text, PT2);
        chk("a_bp_core_key", a_core_key, KEY);
      end
    join
    core_a(CT2, 3);
    recv_a(CT2, 1'b0);

    // Spurious core_done while idle
    a_core_out  = GARB;
    a_core_done = 1'b1;
    @(negedge clk);
    a_core_done = 1'b0;
    @(negedge clk);
    chk("spur_out_vld", a_out_vld, 1'b0);
    chk("spur_in_rdy", a_in_rdy, 1'b1);
    chk("spur_core_ld", a_core_ld, 1'b0);

    // Reset while the core is running, late core_done ignored
    send_a(KEY, PT, 1'b0);
    expect_load_a(KEY, PT);
    rst = 1'b0;
    #1;
    chk("rrun_in_rdy", a_in_rdy, 1'b1);
    chk("rrun_out_vld", a_out_vld, 1'b0);
    chk("rrun_core_text", a_core_text, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    core_a(GARB, 2);
    chk("rrun_late_done_vld", a_out_vld, 1'b0);
    @(negedge clk);
    chk("rrun_late_done_vld2", a_out_vld, 1'b0);
    send_a(KEY, PT2, 1'b0);
    expect_load_a(KEY, PT2);
    core_a(CT2, 3);
    recv_a(CT2, 1'b0);

    // Same vector with 8-bit beats
    send_b(KEY, PT);
    chk("b_rdy_low_after_last", b_in_rdy, 1'b0);
    @(negedge clk);
    chk("b_ld_high", b_core_ld, 1'b1);
    chk("b_core_key", b_core_key, KEY);
    chk("b_core_text", b_core_text, PT);
    repeat (3) @(negedge clk);
    b_core_out  = CT;
    b_core_done = 1'b1;
    @(negedge clk);
    b_core_done = 1'b0;
    recv_b(CT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
